traffic_light_nway: RTL
=======================

// Module: traffic_light_nway
// PURPOSE
//  Parametrised N-approach traffic-light controller; next generation of the 4-way traffic_light.
//  Round-robin service of demanding approaches, with min/max green, yellow and all-red clearance
//  timing, demand gap-out and emergency pre-emption. Drives per-approach lamp enables at the top level.
// PARAMETERS
//  N_WAYS      4   number of approaches (>=2)
//  GREEN_MIN   8   minimum green cycles (>=1)
//  GREEN_MAX   32  maximum green cycles while another approach demands (>=GREEN_MIN)
//  YELLOW_CYC  3   yellow duration in cycles (>=1)
//  ALLRED_CYC  2   all-red clearance in cycles (>=1)
//  WAY_W = $clog2(N_WAYS) (localparam); illegal parameter values -> $fatal at elaboration
// PORTS
//  clk        in   1       system clock, rising edge
//  rst        in   1       asynchronous reset, active-high
//  req        in   N_WAYS  per-approach demand, level, sampled each cycle
//  emg_valid  in   1       emergency pre-emption request
//  emg_way    in   WAY_W   approach to pre-empt to; values >= N_WAYS are ignored
//  green      out  N_WAYS  green lamp, one-hot or zero
//  yellow     out  N_WAYS  yellow lamp, one-hot or zero
//  red        out  N_WAYS  red lamp = ~(green|yellow)
//  cur_way    out  WAY_W   approach currently owning / last owning the right of way
//  grant_strb out  1       one-cycle pulse on the first cycle of every green phase
// BEHAVIOUR
//  - States ALL_RED, GREEN, YELLOW; outputs decoded from registered state/cur_way only (Moore).
//  - Reset (async, immediate): state=ALL_RED, timer=ALLRED_CYC-1, cur_way=0, green=0, yellow=0,
//    red=all ones, grant_strb=0. Reset mid-phase behaves identically; no partial phase resumes.
//  - Down-timer loaded with duration-1 on entry to ALL_RED/YELLOW; leave on cycle timer==0, so
//    each phase is visible exactly ALLRED_CYC / YELLOW_CYC cycles.
//  - ALL_RED expiry -> GREEN on next_way: valid emg_way if emg_valid, else first set req bit
//    searching cur_way+1..N_WAYS-1, 0..cur_way (wrap); none set -> cur_way. grant_strb=1 that cycle.
//  - GREEN: up-counter g_cnt from 0, saturates at GREEN_MAX-1. others = |(req & ~onehot(cur_way)).
//    Exit to YELLOW at the edge where g_cnt>=GREEN_MIN-1 AND others AND (!req[cur_way] OR
//    g_cnt==GREEN_MAX-1). No others -> rest in green indefinitely.
//  - Emergency: emg_valid with valid emg_way!=cur_way in GREEN -> YELLOW next edge, GREEN_MIN ignored.
//    emg_valid with emg_way==cur_way -> green held, no exit, regardless of req. YELLOW/ALL_RED
//    are never shortened by emergency.
//  - Simultaneous events: emergency beats round-robin; max-out and gap-out on same cycle -> one exit.
//  - Invariants: popcount(green|yellow)<=1; yellow only on cur_way; green->yellow->all-red order
//    always kept, never green-to-green directly.
// STRUCTURE
//  - Package traffic_pkg: typedef enum logic [1:0] {TL_ALLRED, TL_GREEN, TL_YELLOW} tl_state_e.
//  - Sub-module rr_next_way #(N_WAYS): combinational round-robin search (req, cur_way -> next_way, any).
//  - Top: state/timer/counter registers, next-state logic, output decode.
// TESTING (defaults N_WAYS=4, GREEN_MIN=8, GREEN_MAX=32, YELLOW_CYC=3, ALLRED_CYC=2)
//  1. rst=1, req=0 -> red=4'b1111; release -> 2 cyc all-red, green=4'b0001, grant_strb 1 cyc, rests.
//  2. way0 green 3 cyc, req=4'b0101 -> green0 held 32 cyc total (own demand), yellow 3, all-red 2, green=4'b0100.
//  3. req=4'b1111 constant -> green order 0,1,2,3,0; each green 32 cyc, period 37 cyc per way.
//  4. req=4'b0011, way0 green; drop req[0] at g_cnt=10 -> yellow=4'b0001 next cycle, then green=4'b0010.
//  5. way0 green g_cnt=2, emg_valid=1 emg_way=2 -> yellow next edge, all-red, green=4'b0100 held
//     while emg_valid with req=4'b1011; emg_valid=0 -> normal exit after g_cnt>=7.
//  6. rst pulsed mid-yellow between edges -> red=4'b1111 instantly; release -> 2 cyc all-red, green=4'b0001.
//  Bench asserts every cycle: green/yellow one-hot-or-zero, red==~(green|yellow), phase lengths exact.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared state encoding and constant helpers for the N-approach traffic-light controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    TL_ALLRED = 2'd0,
    TL_GREEN  = 2'd1,
    TL_YELLOW = 2'd2
  } tl_state_e;

  function automatic int tl_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_next_way.sv
// Round-robin search for the next demanding approach after cur_way, wrapping to cur_way itself.
// Purely combinational; no backpressure (level inputs in, index out).
module rr_next_way #(
  parameter  int N_WAYS = 4,
  localparam int WAY_W  = $clog2(N_WAYS)
) (
  input  logic [N_WAYS-1:0] req,
  input  logic [WAY_W-1:0]  cur_way,
  output logic [WAY_W-1:0]  next_way,
  output logic              any
);

  logic             hi_found;
  logic             lo_found;
  logic [WAY_W-1:0] hi_way;
  logic [WAY_W-1:0] lo_way;

  // Lowest set index above cur_way wins; otherwise lowest set index at or below it.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_way   = '0;
    lo_way   = '0;
    for (int i = 0; i < N_WAYS; i++) begin
      if (req[i] && !hi_found && (i > int'(cur_way))) begin
        hi_found = 1'b1;
        hi_way   = WAY_W'(i);
      end
      if (req[i] && !lo_found && (i <= int'(cur_way))) begin
        lo_found = 1'b1;
        lo_way   = WAY_W'(i);
      end
    end
    any      = |req;
    next_way = hi_found ? hi_way : (lo_found ? lo_way : cur_way);
  end

endmodule

// File: rtl/traffic_light_nway.sv
// N-approach traffic-light controller: round-robin green with min/max, gap-out, yellow, all-red, pre-emption.
// Lamps are a Moore decode of registered state; a decision made at an edge is visible right after it.
// No backpressure: req/emg inputs are level-sampled every cycle, nothing is ever held off.
module traffic_light_nway
  import traffic_pkg::*;
#(
  parameter  int N_WAYS     = 4,
  parameter  int GREEN_MIN  = 8,
  parameter  int GREEN_MAX  = 32,
  parameter  int YELLOW_CYC = 3,
  parameter  int ALLRED_CYC = 2,
  localparam int WAY_W      = $clog2(N_WAYS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_WAYS-1:0] req,
  input  logic              emg_valid,
  input  logic [WAY_W-1:0]  emg_way,
  output logic [N_WAYS-1:0] green,
  output logic [N_WAYS-1:0] yellow,
  output logic [N_WAYS-1:0] red,
  output logic [WAY_W-1:0]  cur_way,
  output logic              grant_strb
);

  if (N_WAYS < 2) begin : g_bad_n_ways
    $fatal(1, "traffic_light_nway: N_WAYS must be >= 2");
  end
  if (GREEN_MIN < 1) begin : g_bad_green_min
    $fatal(1, "traffic_light_nway: GREEN_MIN must be >= 1");
  end
  if (GREEN_MAX < GREEN_MIN) begin : g_bad_green_max
    $fatal(1, "traffic_light_nway: GREEN_MAX must be >= GREEN_MIN");
  end
  if (YELLOW_CYC < 1) begin : g_bad_yellow
    $fatal(1, "traffic_light_nway: YELLOW_CYC must be >= 1");
  end
  if (ALLRED_CYC < 1) begin : g_bad_allred
    $fatal(1, "traffic_light_nway: ALLRED_CYC must be >= 1");
  end

  localparam int TMR_W = $clog2(tl_max(YELLOW_CYC, ALLRED_CYC) + 1);
  localparam int CNT_W = $clog2(GREEN_MAX + 1);

  localparam logic [TMR_W-1:0] T_ALLRED = TMR_W'(ALLRED_CYC - 1);
  localparam logic [TMR_W-1:0] T_YELLOW = TMR_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] G_MIN_M1 = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] G_MAX_M1 = CNT_W'(GREEN_MAX - 1);

  tl_state_e        state, state_nx;
  logic [TMR_W-1:0] timer, timer_nx;
  logic [CNT_W-1:0] g_cnt, g_cnt_nx;
  logic [WAY_W-1:0] cur_way_nx;
  logic             grant_nx;

  logic [N_WAYS-1:0] cur_oh;
  logic              others;
  logic              own;
  logic              emg_ok;
  logic              green_exit;
  logic [WAY_W-1:0]  rr_way;
  logic              rr_any;

  // With a power-of-two N_WAYS every emg_way encoding is a real approach.
  if ((1 << WAY_W) == N_WAYS) begin : g_emg_full
    assign emg_ok = emg_valid;
  end else begin : g_emg_range
    assign emg_ok = emg_valid && (emg_way < WAY_W'(N_WAYS));
  end

  assign cur_oh = N_WAYS'(1) << cur_way;
  assign others = |(req & ~cur_oh);
  assign own    = |(req & cur_oh);

  rr_next_way #(
    .N_WAYS(N_WAYS)
  ) u_rr (
    .req     (req),
    .cur_way (cur_way),
    .next_way(rr_way),
    .any     (rr_any)
  );

  // Emergency toward another way forces exit; emergency toward the owner pins green.
  always_comb begin
    green_exit = 1'b0;
    if (emg_ok) begin
      green_exit = (emg_way != cur_way);
    end else begin
      green_exit = (g_cnt >= G_MIN_M1) && others && (!own || (g_cnt == G_MAX_M1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= TL_ALLRED;
      timer      <= T_ALLRED;
      g_cnt      <= '0;
      cur_way    <= '0;
      grant_strb <= 1'b0;
    end else begin
      state      <= state_nx;
      timer      <= timer_nx;
      g_cnt      <= g_cnt_nx;
      cur_way    <= cur_way_nx;
      grant_strb <= grant_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    timer_nx   = timer;
    g_cnt_nx   = g_cnt;
    cur_way_nx = cur_way;
    grant_nx   = 1'b0;
    case (state)
      TL_ALLRED: begin
        if (timer == '0) begin
          state_nx   = TL_GREEN;
          g_cnt_nx   = '0;
          grant_nx   = 1'b1;
          cur_way_nx = emg_ok ? emg_way : (rr_any ? rr_way : cur_way);
        end else begin
          timer_nx = timer - 1'b1;
        end
      end
      TL_GREEN: begin
        if (g_cnt != G_MAX_M1) begin
          g_cnt_nx = g_cnt + 1'b1;
        end
        if (green_exit) begin
          state_nx = TL_YELLOW;
          timer_nx = T_YELLOW;
        end
      end
      TL_YELLOW: begin
        if (timer == '0) begin
          state_nx = TL_ALLRED;
          timer_nx = T_ALLRED;
        end else begin
          timer_nx = timer - 1'b1;
        end
      end
      default: begin
        state_nx = TL_ALLRED;
        timer_nx = T_ALLRED;
      end
    endcase
  end

  assign green  = (state == TL_GREEN)  ? cur_oh : '0;
  assign yellow = (state == TL_YELLOW) ? cur_oh : '0;
  assign red    = ~(green | yellow);

endmodule
